// File: rtl/rt_ibex_hws_sequencer.sv
// Hardware stacking sequencer: irq accept -> SAVE -> handler,
// mret -> RESTORE (or tail-chain) -> return.
package rt_ibex_hws_pkg;
  typedef enum logic {
    HWS_SAVE    = 1'b0,
    HWS_RESTORE = 1'b1
  } hw_stacking_mode_t;
endpackage

module rt_ibex_hws_sequencer
  import rt_ibex_hws_pkg::*;
#(
  parameter int unsigned IRQ_ID_W      = 8,
  parameter bit          TAIL_CHAIN_EN = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                irq_req_i,
  input  logic [IRQ_ID_W-1:0] irq_id_i,
  input  logic                irq_en_i,
  output logic                irq_ack_o,
  input  logic                mret_i,
  output logic                hws_start_o,
  output hw_stacking_mode_t   hws_mode_o,
  input  logic                hws_done_i,
  output logic                hws_ack_o,
  output logic                fetch_halt_o,
  output logic                handler_jump_o,
  output logic [IRQ_ID_W-1:0] irq_id_o,
  output logic                mret_jump_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    hws_cycles_o
);

  typedef enum logic [3:0] {
    IDLE,
    SAVE_START,
    SAVE_WAIT,
    SAVE_ACK,
    HANDLER,
    RST_START,
    RST_WAIT,
    RST_ACK,
    SETTLE
  } state_t;

  state_t state, state_n;
  state_t after, after_n;

  hw_stacking_mode_t   mode_n;
  logic [IRQ_ID_W-1:0] id_n;
  logic irq_ack_n, start_n, ack_n;
  logic jump_n, mret_jump_n, halt_n;
  logic take, waiting;

  assign take    = irq_req_i & irq_en_i;
  assign waiting = (state == SAVE_WAIT) | (state == RST_WAIT);

  always_comb begin
    state_n     = state;
    after_n     = after;
    mode_n      = hws_mode_o;
    id_n        = irq_id_o;
    irq_ack_n   = 1'b0;
    start_n     = 1'b0;
    ack_n       = 1'b0;
    jump_n      = 1'b0;
    mret_jump_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          id_n      = irq_id_i;
          irq_ack_n = 1'b1;
          mode_n    = HWS_SAVE;
          state_n   = SAVE_START;
        end
      end
      SAVE_START: begin
        start_n = 1'b1;
        state_n = SAVE_WAIT;
      end
      SAVE_WAIT: begin
        if (hws_done_i) begin
          ack_n   = 1'b1;
          jump_n  = 1'b1;
          state_n = SAVE_ACK;
        end
      end
      SAVE_ACK: begin
        after_n = HANDLER;
        state_n = SETTLE;
      end
      HANDLER: begin
        if (mret_i) begin
          if (TAIL_CHAIN_EN && take) begin
            // Saved frame is reused, so only the id changes.
            id_n      = irq_id_i;
            irq_ack_n = 1'b1;
            jump_n    = 1'b1;
          end else begin
            mode_n  = HWS_RESTORE;
            state_n = RST_START;
          end
        end
      end
      RST_START: begin
        start_n = 1'b1;
        state_n = RST_WAIT;
      end
      RST_WAIT: begin
        if (hws_done_i) begin
          ack_n       = 1'b1;
          mret_jump_n = 1'b1;
          state_n     = RST_ACK;
        end
      end
      RST_ACK: begin
        after_n = IDLE;
        state_n = SETTLE;
      end
      SETTLE: begin
        state_n = after;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    halt_n = 1'b0;
    unique case (state_n)
      SAVE_START, SAVE_WAIT, SAVE_ACK,
      RST_START, RST_WAIT, RST_ACK: halt_n = 1'b1;
      SETTLE:  halt_n = !(after_n inside {HANDLER, IDLE});
      default: halt_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      after          <= IDLE;
      hws_mode_o     <= HWS_SAVE;
      irq_id_o       <= '0;
      irq_ack_o      <= 1'b0;
      hws_start_o    <= 1'b0;
      hws_ack_o      <= 1'b0;
      handler_jump_o <= 1'b0;
      mret_jump_o    <= 1'b0;
      fetch_halt_o   <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_n;
      after          <= after_n;
      hws_mode_o     <= mode_n;
      irq_id_o       <= id_n;
      irq_ack_o      <= irq_ack_n;
      hws_start_o    <= start_n;
      hws_ack_o      <= ack_n;
      handler_jump_o <= jump_n;
      mret_jump_o    <= mret_jump_n;
      fetch_halt_o   <= halt_n;
      busy_o         <= (state_n != IDLE);
    end
  end

  // The cycle that observes done is not a waiting cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hws_cycles_o <= '0;
    end else if (waiting && !hws_done_i && (hws_cycles_o != '1)) begin
      hws_cycles_o <= hws_cycles_o + CNT_W'(1);
    end
  end

endmodule
